detector_ctrl: RTL and testbench

Run controller for the serial pattern detector path. It loads a programmable N-bit pattern through a valid/ready handshake and arms a detection run on `start`. During the run it samples `entrada` once per clock and emits a Moore-style `salida` pulse for every occurrence of the pattern, with overlapping matches allowed. It counts matches and ends the run on `stop` or when the count reaches a limit, then holds the result until software acknowledges it with `clear`.

---
 rtl/detector_ctrl.sv | 110 +++++++++++
 tb/tb_detector_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/detector_ctrl.sv
// Run controller for the serial pattern detector: loads a pattern, runs one
// detection pass with overlapping matches, and holds the match count until cleared.
module detector_ctrl #(
  parameter int             N         = 4,
  parameter logic [N-1:0]   PAT_RST   = 4'b1101,
  parameter int             MAX_MATCH = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_valid,
  input  logic [N-1:0] cfg_pattern,
  output logic         cfg_ready,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  input  logic         entrada,
  output logic         salida,
  output logic [7:0]   count,
  output logic [1:0]   estado
);

  localparam int                FILL_W    = $clog2(N + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
  localparam logic [7:0]        LAST_CNT  = 8'(MAX_MATCH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      pat_q, pat_d;
  logic [N-1:0]      sh_q, sh_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              salida_q, salida_d;
  logic [7:0]        count_q, count_d;

  logic [N-1:0]      sh_run;
  logic [FILL_W-1:0] fill_run;
  logic              match_run;

  // Values the shift path would take if this edge samples entrada.
  assign sh_run    = {sh_q[N-2:0], entrada};
  assign fill_run  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
  assign match_run = (fill_run == FILL_FULL) && (sh_run == pat_q);

  always_comb begin
    // NOTE: every signal gets its hold/default value first so no path leaves it unassigned and infers a latch.
    state_d  = state_q;
    pat_d    = pat_q;
    sh_d     = sh_q;
    fill_d   = fill_q;
    count_d  = count_q;
    salida_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_valid) pat_d = cfg_pattern;
        if (start)     state_d = ARMED;
      end
      ARMED: begin
        sh_d    = '0;
        fill_d  = '0;
        count_d = '0;
        state_d = stop ? DONE : RUN;
      end
      RUN: begin
        sh_d   = sh_run;
        fill_d = fill_run;
        if (match_run) begin
          salida_d = 1'b1;
          count_d  = count_q + 8'd1;
        end
        // A match at the exiting edge is still counted and pulsed.
        if (stop || (match_run && (count_q == LAST_CNT))) state_d = DONE;
      end
      DONE: begin
        if (clear) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    if (!rst_n) begin
      state_q  <= IDLE;
      pat_q    <= PAT_RST;
      sh_q     <= '0;
      fill_q   <= '0;
      salida_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      sh_q     <= sh_d;
      fill_q   <= fill_d;
      salida_q <= salida_d;
      count_q  <= count_d;
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign estado    = state_q;
  assign salida    = salida_q;
  assign count     = count_q;

endmodule

// File: tb/tb_detector_ctrl.sv
// Directed bench for detector_ctrl: a default instance plus a MAX_MATCH=2 instance
// share the same stimulus; expected pulses and counts are hand-computed strings.
module tb_detector_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, cfg_valid, start, stop, clear, entrada;
  logic [3:0] cfg_pattern;

  logic       cfg_ready0, salida0, cfg_ready1, salida1;
  logic [7:0] count0, count1;
  logic [1:0] estado0, estado1;

  int tests  = 0;
  int failed = 0;
  int exp0   = 0;
  int exp1   = 0;

  detector_ctrl #(.N(4), .PAT_RST(4'b1101), .MAX_MATCH(255)) dut0 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_pattern(cfg_pattern),
    .cfg_ready(cfg_ready0), .start(start), .stop(stop), .clear(clear),
    .entrada(entrada), .salida(salida0), .count(count0), .estado(estado0)
  );

  detector_ctrl #(.N(4), .PAT_RST(4'b1101), .MAX_MATCH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_pattern(cfg_pattern),
    .cfg_ready(cfg_ready1), .start(start), .stop(stop), .clear(clear),
    .entrada(entrada), .salida(salida1), .count(count1), .estado(estado1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one bit per cycle; p0/p1 mark the bits after which each instance pulses.
  task automatic stream(input string tag, input string bits, input string p0,
                        input string p1, input bit use1);
    for (int i = 0; i < bits.len(); i++) begin
      entrada = (bits[i] == "1");
      tick();
      if (p0[i] == "1") exp0++;
      chk($sformatf("%s.salida0[%0d]", tag, i + 1), 8'(salida0), 8'(p0[i] == "1"));
      chk($sformatf("%s.count0[%0d]", tag, i + 1), count0, 8'(exp0));
      if (use1) begin
        if (p1[i] == "1") exp1++;
        chk($sformatf("%s.salida1[%0d]", tag, i + 1), 8'(salida1), 8'(p1[i] == "1"));
        chk($sformatf("%s.count1[%0d]", tag, i + 1), count1, 8'(exp1));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_pattern = 4'b0000;
    start = 1'b0; stop = 1'b0; clear = 1'b0; entrada = 1'b0;

    // Reset defaults
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst.estado", 8'(estado0), 8'd0);
    chk("rst.cfg_ready", 8'(cfg_ready0), 8'd1);
    chk("rst.salida", 8'(salida0), 8'd0);
    chk("rst.count", count0, 8'd0);

    // Default pattern 1101, mixed stream
    start = 1'b1; tick(); start = 1'b0;
    chk("mix.armed", 8'(estado0), 8'd1);
    chk("mix.cfg_ready_armed", 8'(cfg_ready0), 8'd0);
    tick();
    chk("mix.run", 8'(estado0), 8'd2);
    stream("mix", "110101111101011001", "000100000001000000", "000100000001000000", 1'b1);
    chk("mix.limit_done1", 8'(estado1), 8'd3);
    entrada = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
    chk("mix.stop_estado", 8'(estado0), 8'd3);
    chk("mix.stop_count", count0, 8'd2);
    chk("mix.stop_salida", 8'(salida0), 8'd0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("mix.clear_estado", 8'(estado0), 8'd0);
    chk("mix.clear_count_held", count0, 8'd2);
    chk("mix.clear_estado1", 8'(estado1), 8'd0);

    // Overlap on instance 0, limit on instance 1
    cfg_valid = 1'b1; cfg_pattern = 4'b1101; tick(); cfg_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    exp0 = 0; exp1 = 0;
    chk("ovl.count_cleared", count0, 8'd0);
    stream("ovl", "1101101", "0001001", "0001001", 1'b1);
    chk("lim.done_at_bit7", 8'(estado1), 8'd3);
    chk("ovl.still_run", 8'(estado0), 8'd2);
    stream("lim", "101", "001", "000", 1'b1);

    // Configuration offered during RUN is dropped
    cfg_valid = 1'b1; cfg_pattern = 4'b0110;
    chk("gate.cfg_ready_run", 8'(cfg_ready0), 8'd0);
    stream("gate", "101", "001", "000", 1'b0);
    cfg_valid = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    chk("gate.stop_estado", 8'(estado0), 8'd3);
    chk("gate.stop_count", count0, 8'd4);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("gate.idle", 8'(estado0), 8'd0);

    // Load together with start: run uses the new pattern
    cfg_valid = 1'b1; cfg_pattern = 4'b0110; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    chk("newpat.armed", 8'(estado0), 8'd1);
    chk("newpat.count_before_clear", count0, 8'd4);
    tick();
    exp0 = 0;
    chk("newpat.run", 8'(estado0), 8'd2);
    chk("newpat.count_cleared", count0, 8'd0);
    stream("newpat", "0110", "0001", "0000", 1'b0);

    // Reset mid-run beats a matching bit at the same edge
    stream("prerst", "11", "00", "00", 1'b0);
    entrada = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp0 = 0;
    chk("midrst.estado", 8'(estado0), 8'd0);
    chk("midrst.count", count0, 8'd0);
    chk("midrst.salida", 8'(salida0), 8'd0);
    chk("midrst.cfg_ready", 8'(cfg_ready0), 8'd1);

    // Stop while ARMED
    start = 1'b1; tick(); start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    chk("armstop.estado", 8'(estado0), 8'd3);
    chk("armstop.count", count0, 8'd0);
    chk("armstop.salida", 8'(salida0), 8'd0);

    // Pattern returned to 1101 after reset
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    stream("rstpat", "1101", "0001", "0000", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
